// File: rtl/rename_credit_controller.sv
// Rename-stage credit pool: tracks free AL/IQ/LQ/SQ entries and grants a rename group
// only when every op in it fits, with all-or-nothing allocation.
module rename_credit_controller #(
    parameter int unsigned RENAME_WIDTH = 2,
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned AL_ENTRIES   = 64,
    parameter int unsigned IQ_ENTRIES   = 16,
    parameter int unsigned LQ_ENTRIES   = 16,
    parameter int unsigned SQ_ENTRIES   = 16,
    localparam int unsigned REL_W = $clog2(COMMIT_WIDTH + 1),
    localparam int unsigned AL_W  = $clog2(AL_ENTRIES + 1),
    localparam int unsigned IQ_W  = $clog2(IQ_ENTRIES + 1),
    localparam int unsigned LQ_W  = $clog2(LQ_ENTRIES + 1),
    localparam int unsigned SQ_W  = $clog2(SQ_ENTRIES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RENAME_WIDTH-1:0] req_valid,
    input  logic [RENAME_WIDTH-1:0] req_is_load,
    input  logic [RENAME_WIDTH-1:0] req_is_store,
    input  logic                    stall,
    input  logic                    clear,
    input  logic [REL_W-1:0]        al_release,
    input  logic [REL_W-1:0]        iq_release,
    input  logic [REL_W-1:0]        lq_release,
    input  logic [REL_W-1:0]        sq_release,
    input  logic                    recover,
    input  logic [AL_W-1:0]         recover_al_used,
    input  logic [IQ_W-1:0]         recover_iq_used,
    input  logic [LQ_W-1:0]         recover_lq_used,
    input  logic [SQ_W-1:0]         recover_sq_used,
    output logic [RENAME_WIDTH-1:0] grant,
    output logic                    allocatable,
    output logic                    send_bubble,
    output logic [AL_W-1:0]         al_free,
    output logic [IQ_W-1:0]         iq_free,
    output logic [LQ_W-1:0]         lq_free,
    output logic [SQ_W-1:0]         sq_free,
    output logic                    credit_err,
    output logic [31:0]             stall_cycles
);

    int unsigned n_all, n_ld, n_st;
    logic        fire;
    logic [AL_W:0] al_sum;
    logic [IQ_W:0] iq_sum;
    logic [LQ_W:0] lq_sum;
    logic [SQ_W:0] sq_sum;
    logic [AL_W-1:0] al_free_d;
    logic [IQ_W-1:0] iq_free_d;
    logic [LQ_W-1:0] lq_free_d;
    logic [SQ_W-1:0] sq_free_d;
    logic al_err, iq_err, lq_err, sq_err;

    always_comb begin
        n_all = 0;
        n_ld  = 0;
        n_st  = 0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (req_valid[i]) begin
                n_all = n_all + 1;
                if (req_is_load[i])  n_ld = n_ld + 1;
                if (req_is_store[i]) n_st = n_st + 1;
            end
        end
    end

    assign allocatable = (32'(al_free) >= n_all) && (32'(iq_free) >= n_all) &&
                         (32'(lq_free) >= n_ld) && (32'(sq_free) >= n_st);
    // Kept free of stall/clear so the controller sees no combinational loop.
    assign send_bubble = (|req_valid) && !allocatable;
    assign fire        = allocatable && !stall && !clear && !recover && !rst;
    assign grant       = fire ? req_valid : '0;

    always_comb begin
        al_sum = {1'b0, al_free} - (fire ? (AL_W+1)'(n_all) : '0) + (AL_W+1)'(al_release);
        iq_sum = {1'b0, iq_free} - (fire ? (IQ_W+1)'(n_all) : '0) + (IQ_W+1)'(iq_release);
        lq_sum = {1'b0, lq_free} - (fire ? (LQ_W+1)'(n_ld) : '0) + (LQ_W+1)'(lq_release);
        sq_sum = {1'b0, sq_free} - (fire ? (SQ_W+1)'(n_st) : '0) + (SQ_W+1)'(sq_release);
        al_err = 1'b0;
        iq_err = 1'b0;
        lq_err = 1'b0;
        sq_err = 1'b0;
        al_free_d = al_sum[AL_W-1:0];
        iq_free_d = iq_sum[IQ_W-1:0];
        lq_free_d = lq_sum[LQ_W-1:0];
        sq_free_d = sq_sum[SQ_W-1:0];
        if (recover) begin
            // Occupancy above capacity is unrecoverable: drop to zero credits and flag it.
            if (32'(recover_al_used) > AL_ENTRIES) begin al_free_d = '0; al_err = 1'b1; end
            else al_free_d = AL_W'(AL_ENTRIES - 32'(recover_al_used));
            if (32'(recover_iq_used) > IQ_ENTRIES) begin iq_free_d = '0; iq_err = 1'b1; end
            else iq_free_d = IQ_W'(IQ_ENTRIES - 32'(recover_iq_used));
            if (32'(recover_lq_used) > LQ_ENTRIES) begin lq_free_d = '0; lq_err = 1'b1; end
            else lq_free_d = LQ_W'(LQ_ENTRIES - 32'(recover_lq_used));
            if (32'(recover_sq_used) > SQ_ENTRIES) begin sq_free_d = '0; sq_err = 1'b1; end
            else sq_free_d = SQ_W'(SQ_ENTRIES - 32'(recover_sq_used));
        end else begin
            if (al_sum > (AL_W+1)'(AL_ENTRIES)) begin al_free_d = AL_W'(AL_ENTRIES); al_err = 1'b1; end
            if (iq_sum > (IQ_W+1)'(IQ_ENTRIES)) begin iq_free_d = IQ_W'(IQ_ENTRIES); iq_err = 1'b1; end
            if (lq_sum > (LQ_W+1)'(LQ_ENTRIES)) begin lq_free_d = LQ_W'(LQ_ENTRIES); lq_err = 1'b1; end
            if (sq_sum > (SQ_W+1)'(SQ_ENTRIES)) begin sq_free_d = SQ_W'(SQ_ENTRIES); sq_err = 1'b1; end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al_free      <= AL_W'(AL_ENTRIES);
            iq_free      <= IQ_W'(IQ_ENTRIES);
            lq_free      <= LQ_W'(LQ_ENTRIES);
            sq_free      <= SQ_W'(SQ_ENTRIES);
            credit_err   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            al_free    <= al_free_d;
            iq_free    <= iq_free_d;
            lq_free    <= lq_free_d;
            sq_free    <= sq_free_d;
            credit_err <= credit_err | al_err | iq_err | lq_err | sq_err;
            if (send_bubble) stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_rename_credit_controller.sv
// Directed plus randomized bench for rename_credit_controller, checked against a
// counter-level credit model kept in the bench.
module tb_rename_credit_controller;

    localparam int unsigned AL_N = 64;
    localparam int unsigned IQ_N = 16;
    localparam int unsigned LQ_N = 16;
    localparam int unsigned SQ_N = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_is_load, req_is_store;
    logic       stall, clear, recover;
    logic [1:0] al_release, iq_release, lq_release, sq_release;
    logic [6:0] recover_al_used;
    logic [4:0] recover_iq_used, recover_lq_used, recover_sq_used;
    logic [1:0] grant;
    logic       allocatable, send_bubble, credit_err;
    logic [6:0] al_free;
    logic [4:0] iq_free, lq_free, sq_free;
    logic [31:0] stall_cycles;

    int unsigned vecs = 0;
    int unsigned miscompares = 0;

    int unsigned m_al, m_iq, m_lq, m_sq;
    logic        m_err;
    logic [31:0] m_stall;

    rename_credit_controller dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_is_load(req_is_load), .req_is_store(req_is_store),
        .stall(stall), .clear(clear),
        .al_release(al_release), .iq_release(iq_release),
        .lq_release(lq_release), .sq_release(sq_release),
        .recover(recover),
        .recover_al_used(recover_al_used), .recover_iq_used(recover_iq_used),
        .recover_lq_used(recover_lq_used), .recover_sq_used(recover_sq_used),
        .grant(grant), .allocatable(allocatable), .send_bubble(send_bubble),
        .al_free(al_free), .iq_free(iq_free), .lq_free(lq_free), .sq_free(sq_free),
        .credit_err(credit_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned reload(input int unsigned cap, input int unsigned used);
        if (used > cap) begin
            m_err = 1'b1;
            return 0;
        end
        return cap - used;
    endfunction

    function automatic int unsigned settle(input int unsigned cap, input int unsigned v);
        if (v > cap) begin
            m_err = 1'b1;
            return cap;
        end
        return v;
    endfunction

    task automatic idle();
        req_valid = 2'b00; req_is_load = 2'b00; req_is_store = 2'b00;
        stall = 1'b0; clear = 1'b0; recover = 1'b0;
        al_release = 2'd0; iq_release = 2'd0; lq_release = 2'd0; sq_release = 2'd0;
        recover_al_used = '0; recover_iq_used = '0; recover_lq_used = '0; recover_sq_used = '0;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [1:0] ld, input logic [1:0] st);
        req_valid = v; req_is_load = ld; req_is_store = st;
    endtask

    task automatic model_reset();
        m_al = AL_N; m_iq = IQ_N; m_lq = LQ_N; m_sq = SQ_N;
        m_err = 1'b0; m_stall = 32'd0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_al_free"}, 32'(al_free), m_al);
        chk({tag, "_iq_free"}, 32'(iq_free), m_iq);
        chk({tag, "_lq_free"}, 32'(lq_free), m_lq);
        chk({tag, "_sq_free"}, 32'(sq_free), m_sq);
        chk({tag, "_credit_err"}, 32'(credit_err), 32'(m_err));
        chk({tag, "_stall_cycles"}, stall_cycles, m_stall);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_reset();
        #3;
        check_regs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Inputs are already driven at the negedge; check outputs, then advance the model.
    task automatic cycle(input string tag);
        int unsigned na, nl, ns;
        logic alloc, bub, fire;
        #1;
        na = 0; nl = 0; ns = 0;
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i]) begin
                na++;
                if (req_is_load[i])  nl++;
                if (req_is_store[i]) ns++;
            end
        end
        alloc = (m_al >= na) && (m_iq >= na) && (m_lq >= nl) && (m_sq >= ns);
        bub   = (na != 0) && !alloc;
        fire  = alloc && !stall && !clear && !recover;
        chk({tag, "_grant"}, 32'(grant), fire ? 32'(req_valid) : 32'd0);
        chk({tag, "_allocatable"}, 32'(allocatable), 32'(alloc));
        chk({tag, "_send_bubble"}, 32'(send_bubble), 32'(bub));
        if (recover) begin
            m_al = reload(AL_N, recover_al_used);
            m_iq = reload(IQ_N, recover_iq_used);
            m_lq = reload(LQ_N, recover_lq_used);
            m_sq = reload(SQ_N, recover_sq_used);
        end else begin
            m_al = settle(AL_N, m_al - (fire ? na : 0) + al_release);
            m_iq = settle(IQ_N, m_iq - (fire ? na : 0) + iq_release);
            m_lq = settle(LQ_N, m_lq - (fire ? nl : 0) + lq_release);
            m_sq = settle(SQ_N, m_sq - (fire ? ns : 0) + sq_release);
        end
        if (bub) m_stall = m_stall + 32'd1;
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Two-op group with one load.
        idle(); set_req(2'b11, 2'b01, 2'b00); cycle("grp");
        chk("grp_al62", 32'(al_free), 32'd62);
        chk("grp_iq14", 32'(iq_free), 32'd14);
        chk("grp_lq15", 32'(lq_free), 32'd15);

        // Drain IQ to one credit, then a two-op group must bubble.
        repeat (6) begin
            @(negedge clk); idle(); set_req(2'b11, 2'b00, 2'b00); cycle("drain");
        end
        @(negedge clk); idle(); set_req(2'b01, 2'b00, 2'b00); cycle("drain1");
        chk("iq_one", 32'(iq_free), 32'd1);
        @(negedge clk); idle(); set_req(2'b11, 2'b00, 2'b00); cycle("iq_short");
        chk("iq_short_stall", stall_cycles, 32'd1);
        @(negedge clk); idle(); set_req(2'b11, 2'b00, 2'b00); iq_release = 2'd1;
        cycle("iq_rel");
        chk("iq_two", 32'(iq_free), 32'd2);
        @(negedge clk); idle(); set_req(2'b11, 2'b00, 2'b00); cycle("iq_regrant");

        // Exhaust SQ while AL/IQ are replenished each cycle.
        @(negedge clk); do_reset();
        repeat (8) begin
            idle(); set_req(2'b11, 2'b00, 2'b11); al_release = 2'd2; iq_release = 2'd2;
            cycle("sq_fill");
            @(negedge clk);
        end
        chk("sq_zero", 32'(sq_free), 32'd0);
        idle(); set_req(2'b11, 2'b00, 2'b10); sq_release = 2'd2; cycle("sq_rel");
        chk("sq_two", 32'(sq_free), 32'd2);
        @(negedge clk); idle(); set_req(2'b11, 2'b00, 2'b10); cycle("sq_regrant");

        // Stall and clear suppress grants without bubbling.
        @(negedge clk); do_reset();
        idle(); set_req(2'b11, 2'b00, 2'b00); stall = 1'b1; cycle("stall");
        @(negedge clk); idle(); set_req(2'b11, 2'b00, 2'b00); clear = 1'b1; cycle("clear");
        chk("stall_clear_al", 32'(al_free), 32'd64);

        // Recovery overrides a coincident grant and release.
        @(negedge clk); idle(); set_req(2'b11, 2'b01, 2'b00); recover = 1'b1;
        recover_al_used = 7'd10; recover_lq_used = 5'd3; al_release = 2'd2;
        cycle("recover");
        chk("recover_al54", 32'(al_free), 32'd54);
        chk("recover_lq13", 32'(lq_free), 32'd13);

        // Release at full capacity saturates and latches the error.
        @(negedge clk); do_reset();
        idle(); al_release = 2'd1; cycle("ovf");
        chk("ovf_err", 32'(credit_err), 32'd1);
        @(negedge clk); idle(); set_req(2'b11, 2'b00, 2'b00); cycle("ovf_hold");

        // Asynchronous reset mid-cycle.
        @(negedge clk); idle(); set_req(2'b11, 2'b00, 2'b00);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_al", 32'(al_free), 32'd64);
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_err", 32'(credit_err), 32'd0);
        @(negedge clk); rst = 1'b0; idle();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (n % 100 == 99) begin
                do_reset();
            end
            idle();
            set_req(2'($urandom), 2'($urandom), 2'($urandom));
            stall = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 15) == 0);
            al_release = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            iq_release = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            lq_release = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            sq_release = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            if ($urandom_range(0, 15) == 0) begin
                recover = 1'b1;
                recover_al_used = ($urandom_range(0, 9) == 0) ? 7'(AL_N + 1)
                                                               : 7'($urandom_range(0, AL_N));
                recover_iq_used = 5'($urandom_range(0, IQ_N));
                recover_lq_used = ($urandom_range(0, 9) == 0) ? 5'(LQ_N + 1)
                                                               : 5'($urandom_range(0, LQ_N));
                recover_sq_used = 5'($urandom_range(0, SQ_N));
            end
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/rename_credit_controller.md
Name: rename_credit_controller

Overview:
- Credit-based allocation controller for the rename stage.
- Tracks free entries in the active list, issue queue, load queue and store queue, and decides each cycle whether the whole rename group can be allocated.
- Drives per-slot allocate grants and the send-bubble request to the pipeline controller.
- Replaces per-resource allocatable probing with one sequenced credit pool, rebuilt on flush recovery.

Parameters:
- RENAME_WIDTH, 2, ops per rename group.
- COMMIT_WIDTH, 2, max entries released per resource per cycle.
- AL_ENTRIES, 64, active list capacity.
- IQ_ENTRIES, 16, issue queue capacity.
- LQ_ENTRIES, 16, load queue capacity.
- SQ_ENTRIES, 16, store queue capacity.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  RENAME_WIDTH  valid ops in the rename pipeline register
- req_is_load  in  RENAME_WIDTH  op is a load
- req_is_store  in  RENAME_WIDTH  op is a store
- stall  in  1  rename stage stall from the controller
- clear  in  1  rename stage clear from the controller
- al_release  in  clog2(COMMIT_WIDTH+1)  active list entries freed this cycle
- iq_release  in  clog2(COMMIT_WIDTH+1)  issue queue entries freed
- lq_release  in  clog2(COMMIT_WIDTH+1)  load queue entries freed
- sq_release  in  clog2(COMMIT_WIDTH+1)  store queue entries freed
- recover  in  1  flush recovery; reload credits
- recover_al_used  in  clog2(AL_ENTRIES+1)  surviving active list occupancy
- recover_iq_used  in  clog2(IQ_ENTRIES+1)  surviving issue queue occupancy
- recover_lq_used  in  clog2(LQ_ENTRIES+1)  surviving load queue occupancy
- recover_sq_used  in  clog2(SQ_ENTRIES+1)  surviving store queue occupancy
- grant  out  RENAME_WIDTH  allocate strobe per slot
- allocatable  out  1  group fits in all resources
- send_bubble  out  1  rename requests a bubble/stall to the controller
- al_free, iq_free, lq_free, sq_free  out  clog2(N+1) each  current credit counts
- credit_err  out  1  sticky overflow error
- stall_cycles  out  32  performance counter

Behaviour:
- Reset (async, rst=1):
  - al_free=AL_ENTRIES, iq_free=IQ_ENTRIES, lq_free=LQ_ENTRIES, sq_free=SQ_ENTRIES.
  - credit_err=0, stall_cycles=0.
- Combinational need per resource:
  - need_al = need_iq = popcount(req_valid).
  - need_lq = popcount(req_valid & req_is_load).
  - need_sq = popcount(req_valid & req_is_store).
  - Load and store flags on invalid slots are ignored.
- allocatable = (al_free>=need_al) && (iq_free>=need_iq) && (lq_free>=need_lq) && (sq_free>=need_sq). It is 1 when req_valid=0.
- send_bubble = (|req_valid) && !allocatable.
  - It depends only on current credits and requests, never on stall or clear, so the controller sees no combinational loop.
- grant[i] = req_valid[i] && allocatable && !stall && !clear && !recover.
  - Allocation is all-or-nothing: there are no partial group grants.
- Credit update at each posedge, evaluated in this priority:
  1. recover=1: X_free <= X_ENTRIES - recover_X_used. Grants and releases that cycle are discarded. recover_X_used > X_ENTRIES loads 0 and sets credit_err.
  2. Otherwise: X_free <= X_free - granted_X + X_release, computed at width clog2(N+1)+1.
     - A result above X_ENTRIES clamps to X_ENTRIES and sets credit_err.
     - Underflow cannot occur because grant requires credit.
- Allocation and release in the same cycle both apply. A release does not enable a grant in the same cycle; credits become visible the next cycle.
- stall_cycles increments by 1 in each cycle with send_bubble=1, and wraps at 2^32.
- credit_err clears only on rst.
- Outputs *_free are direct register values, with zero combinational latency from state.
- Reset asserted mid-operation restores full credits immediately; grant goes to 0 while rst=1.

Test Plan:
- After reset, req_valid=2'b11, req_is_load=2'b01, no stall -> grant=11, allocatable=1. Next cycle al_free=62, iq_free=14, lq_free=15, sq_free=16.
- iq_free=1, req_valid=11 -> allocatable=0, send_bubble=1, grant=00, stall_cycles increments. Then iq_release=1 -> next cycle iq_free=2, grant=11.
- sq_free=0, store in slot1 and sq_release=2 in the same cycle -> grant=00 that cycle. Next cycle sq_free=2, grant=11.
- stall=1 with full credits and req_valid=11 -> grant=00, send_bubble=0, credits unchanged. Same check with clear=1.
- recover=1, recover_al_used=10, recover_lq_used=3, with a simultaneous grant and al_release=2 -> al_free=54, lq_free=13, iq_free=16, sq_free=16. Grant suppressed.
- At al_free=64, al_release=1 -> al_free stays 64, credit_err=1 and stays 1 until rst. Asserting rst mid-sequence -> credits return to full asynchronously.
